seg7_capture: RTL and testbench

Display-side decoder that watches a multiplexed two-digit 7-segment drive bus and recovers the hex value on each digit. It samples the segment pattern and digit select, accepts a pattern only after it has been stable for a set number of enabled samples, and decodes it back to a 4-bit hex value. Each digit keeps its own result register. Used in loopback self-test and for board-level checking of anything driving the Go Board display, including the hex-to-segment encoder path.

---
 rtl/seg7_capture_pkg.sv | 28 ++
 rtl/seg7_to_hex.sv | 23 ++
 rtl/seg7_capture.sv | 123 ++++++++++++
 tb/tb_seg7_capture.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_capture_pkg.sv
// Shared 7-segment definitions: legal hex codes, blank code, capture FSM states, decoder result.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Segment bit order in every 7-bit pattern: bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
package seg7_capture_pkg;

  // Pattern with no segments lit: a digit intentionally left dark.
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Segment pattern for each hex value, indexed by the value it displays.
  localparam logic [6:0] SEG_CODE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // nothing sampled since reset
    ST_TRACK = 2'd1,  // counting a run of identical samples
    ST_HELD  = 2'd2   // run accepted, waiting for the input to move
  } cap_state_t;

  typedef struct packed {
    logic       legal;  // pattern is one of the 16 hex codes
    logic       blank;  // pattern is the all-dark code
    logic [3:0] hex;    // decoded value, 0 unless legal
  } seg_dec_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Reverse lookup from a 7-segment pattern to {legal, blank, hex}.
// Latency: combinational.
// Backpressure: none.
module seg7_to_hex
  import seg7_capture_pkg::*;
(
  input  logic [6:0] i_seg,
  output seg_dec_t   o_dec
);

  // Match the pattern against every legal code; at most one can hit.
  always_comb begin
    o_dec       = '0;
    o_dec.blank = (i_seg == SEG_BLANK);
    for (int k = 0; k < 16; k++) begin
      if (i_seg == SEG_CODE[k]) begin
        o_dec.legal = 1'b1;
        o_dec.hex   = 4'(k);
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Recovers per-digit hex values from a multiplexed 2-digit 7-segment bus after a stable dwell.
// Latency: outputs update on the STABLE_CYCLES-th consecutive enabled identical sample; o_update follows for one cycle.
// Backpressure: none; the bus is passively sampled, i_en low simply pauses sampling.
module seg7_capture
  import seg7_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_seg,
  input  logic       i_digit,
  input  logic       i_en,
  input  logic       i_err_clr,
  output logic [3:0] o_hex0,
  output logic [3:0] o_hex1,
  output logic       o_valid0,
  output logic       o_valid1,
  output logic       o_update,
  output logic       o_err
);

  localparam int              CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(STABLE_CYCLES);

  cap_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_tuple;
  logic [3:0]    r_hex0;
  logic [3:0]    r_hex1;
  logic          r_valid0;
  logic          r_valid1;
  logic          r_update;
  logic          r_err;

  logic [7:0]    w_tuple;
  logic          w_same;
  seg_dec_t      w_dec;

  assign w_tuple = {i_digit, i_seg};
  assign w_same  = (w_tuple == r_tuple);

  // On an accepting edge the held tuple equals the input, so decoding the
  // register keeps the input pins off the decoder path.
  seg7_to_hex u_dec (
    .i_seg (r_tuple[6:0]),
    .o_dec (w_dec)
  );

  // Run tracking FSM plus the per-digit result registers and sticky error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_tuple  <= '0;
      r_hex0   <= '0;
      r_hex1   <= '0;
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      r_update <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_update <= 1'b0;
      // Clear first so an illegal accept on the same edge overrides it.
      if (i_err_clr) r_err <= 1'b0;
      if (i_en) begin
        case (r_state)
          ST_IDLE: begin
            r_tuple <= w_tuple;
            r_cnt   <= CNT_ONE;
            r_state <= ST_TRACK;
          end
          ST_TRACK: begin
            if (!w_same) begin
              r_tuple <= w_tuple;
              r_cnt   <= CNT_ONE;
            end else if (r_cnt == CNT_LAST) begin
              r_cnt    <= CNT_FULL;
              r_state  <= ST_HELD;
              r_update <= 1'b1;
              if (w_dec.legal) begin
                if (r_tuple[7]) begin
                  r_hex1   <= w_dec.hex;
                  r_valid1 <= 1'b1;
                end else begin
                  r_hex0   <= w_dec.hex;
                  r_valid0 <= 1'b1;
                end
              end else begin
                if (r_tuple[7]) r_valid1 <= 1'b0;
                else            r_valid0 <= 1'b0;
                if (!w_dec.blank) r_err <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          ST_HELD: begin
            if (!w_same) begin
              r_tuple <= w_tuple;
              r_cnt   <= CNT_ONE;
              r_state <= ST_TRACK;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_hex0   = r_hex0;
  assign o_hex1   = r_hex1;
  assign o_valid0 = r_valid0;
  assign o_valid1 = r_valid1;
  assign o_update = r_update;
  assign o_err    = r_err;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios plus a random soak against a run-length model.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_capture;

  localparam int N = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [6:0] i_seg = 7'h00;
  logic       i_digit = 1'b0;
  logic       i_en = 1'b0;
  logic       i_err_clr = 1'b0;
  logic [3:0] o_hex0, o_hex1;
  logic       o_valid0, o_valid1, o_update, o_err;
  logic [11:0] w_obs;

  int n_checks = 0;
  int n_fail = 0;

  seg7_capture #(.STABLE_CYCLES(N)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_seg(i_seg), .i_digit(i_digit),
    .i_en(i_en), .i_err_clr(i_err_clr), .o_hex0(o_hex0), .o_hex1(o_hex1),
    .o_valid0(o_valid0), .o_valid1(o_valid1), .o_update(o_update), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  assign w_obs = {o_hex1, o_hex0, o_valid1, o_valid0, o_update, o_err};

  // ---------------- reference model (run-length view of the bus) ----------------
  logic [6:0] codes [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [7:0] m_prev;
  bit         m_have;
  int         m_run;
  logic [3:0] m_hex [2];
  bit         m_valid [2];
  bit         m_upd, m_err;

  function automatic void model_reset();
    m_prev = '0; m_have = 0; m_run = 0;
    m_hex[0] = 4'h0; m_hex[1] = 4'h0; m_valid[0] = 0; m_valid[1] = 0;
    m_upd = 0; m_err = 0;
  endfunction

  function automatic void model_edge(input logic [6:0] seg, input logic dig,
                                     input logic en, input logic clr);
    bit acc = 0;
    int idx = -1;
    m_upd = 0;
    if (en) begin
      if (m_have && {dig, seg} == m_prev) m_run++;
      else m_run = 1;
      m_have = 1;
      m_prev = {dig, seg};
      acc = (m_run == N);
    end
    if (clr) m_err = 0;
    if (acc) begin
      m_upd = 1;
      for (int k = 0; k < 16; k++) if (codes[k] == seg) idx = k;
      if (idx >= 0) begin
        m_hex[dig] = 4'(idx);
        m_valid[dig] = 1;
      end else begin
        m_valid[dig] = 0;
        if (seg != 7'h00) m_err = 1;
      end
    end
  endfunction

  function automatic logic [11:0] model_vec();
    return {m_hex[1], m_hex[0], m_valid[1], m_valid[0], m_upd, m_err};
  endfunction

  // Drive one cycle from a falling edge, advance the model on the rising edge.
  task automatic tick(input logic [6:0] seg, input logic dig, input logic en, input logic clr);
    i_seg = seg; i_digit = dig; i_en = en; i_err_clr = clr;
    @(posedge i_clk);
    model_edge(seg, dig, en, clr);
    @(negedge i_clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    n_checks++;
    if (w_obs !== 12'h000) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", w_obs, 12'h000);
    end
    i_rst_n = 1'b1;
  endtask

  task automatic test_digit0_hold();
    for (int i = 1; i <= 6; i++) begin
      tick(7'h7E, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (w_obs !== model_vec()) begin
        n_fail++; $display("FAIL d0_hold_model[%0d]: got %h want %h", i, w_obs, model_vec());
      end
      n_checks++;
      if ({o_valid0, o_update} !== {(i >= 4) ? 1'b1 : 1'b0, (i == 4) ? 1'b1 : 1'b0}) begin
        n_fail++; $display("FAIL d0_hold_timing[%0d]: valid0/update got %b%b", i, o_valid0, o_update);
      end
    end
    n_checks++;
    if ({o_hex0, o_valid1} !== {4'h0, 1'b0}) begin
      n_fail++; $display("FAIL d0_hold_final: hex0=%h valid1=%b want 0/0", o_hex0, o_valid1);
    end
  endtask

  task automatic test_digit1();
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick(7'h47, 1'b1, 1'b1, 1'b0);
      pulses += int'(o_update);
    end
    n_checks++;
    if ({o_hex1, o_valid1} !== {4'hF, 1'b1}) begin
      n_fail++; $display("FAIL d1_F: hex1=%h valid1=%b want f/1", o_hex1, o_valid1);
    end
    for (int i = 0; i < 5; i++) begin
      tick(7'h3D, 1'b1, 1'b1, 1'b0);
      pulses += int'(o_update);
    end
    n_checks++;
    if ({o_hex1, o_valid1, o_hex0, o_valid0} !== {4'hD, 1'b1, 4'h0, 1'b1}) begin
      n_fail++; $display("FAIL d1_D: hex1=%h v1=%b hex0=%h v0=%b want d/1/0/1",
                         o_hex1, o_valid1, o_hex0, o_valid0);
    end
    n_checks++;
    if (pulses !== 2) begin
      n_fail++; $display("FAIL d1_pulses: got %0d want 2", pulses);
    end
    n_checks++;
    if (w_obs !== model_vec()) begin
      n_fail++; $display("FAIL d1_model: got %h want %h", w_obs, model_vec());
    end
  endtask

  task automatic test_short_run();
    int pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick(7'h7E, 1'b0, 1'b1, 1'b0);
      pulses += int'(o_update);
    end
    for (int i = 0; i < 4; i++) begin
      tick(7'h30, 1'b0, 1'b1, 1'b0);
      pulses += int'(o_update);
    end
    n_checks++;
    if ({pulses == 1, o_hex0, o_valid0} !== {1'b1, 4'h1, 1'b1}) begin
      n_fail++; $display("FAIL short_run: pulses=%0d hex0=%h want 1 pulse hex0=1", pulses, o_hex0);
    end
    n_checks++;
    if (w_obs !== model_vec()) begin
      n_fail++; $display("FAIL short_run_model: got %h want %h", w_obs, model_vec());
    end
  endtask

  task automatic test_illegal();
    repeat (4) tick(7'h01, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({o_err, o_valid0, o_hex0} !== {1'b1, 1'b0, 4'h1}) begin
      n_fail++; $display("FAIL illegal_set: err=%b v0=%b hex0=%h want 1/0/1", o_err, o_valid0, o_hex0);
    end
    repeat (3) tick(7'h02, 1'b0, 1'b1, 1'b0);
    tick(7'h02, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({o_err, o_update} !== 2'b11) begin
      n_fail++; $display("FAIL illegal_set_wins: err=%b update=%b want 1/1", o_err, o_update);
    end
    tick(7'h02, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (o_err !== 1'b0) begin
      n_fail++; $display("FAIL illegal_clear: err=%b want 0", o_err);
    end
    n_checks++;
    if (w_obs !== model_vec()) begin
      n_fail++; $display("FAIL illegal_model: got %h want %h", w_obs, model_vec());
    end
  endtask

  task automatic test_enable_gap();
    int early = 0;
    repeat (2) begin tick(7'h7B, 1'b0, 1'b1, 1'b0); early += int'(o_update); end
    repeat (5) begin tick(7'($urandom), 1'($urandom), 1'b0, 1'b0); early += int'(o_update); end
    tick(7'h7B, 1'b0, 1'b1, 1'b0); early += int'(o_update);
    n_checks++;
    if ({early == 0, o_valid0} !== 2'b10) begin
      n_fail++; $display("FAIL gap_early: pulses=%0d v0=%b want 0/0", early, o_valid0);
    end
    tick(7'h7B, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({o_hex0, o_valid0, o_update} !== {4'h9, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL gap_accept: hex0=%h v0=%b upd=%b want 9/1/1", o_hex0, o_valid0, o_update);
    end
    repeat (4) tick(7'h00, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({o_hex0, o_valid0, o_err} !== {4'h9, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL blank: hex0=%h v0=%b err=%b want 9/0/0", o_hex0, o_valid0, o_err);
    end
    n_checks++;
    if (w_obs !== model_vec()) begin
      n_fail++; $display("FAIL gap_model: got %h want %h", w_obs, model_vec());
    end
  endtask

  task automatic test_reset_mid();
    repeat (2) tick(7'h7E, 1'b1, 1'b1, 1'b0);
    #2 i_rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (w_obs !== 12'h000) begin
      n_fail++; $display("FAIL reset_async: got %h want %h", w_obs, 12'h000);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(7'h7E, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (o_valid1 !== ((i == 4) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL reset_recount[%0d]: valid1=%b", i, o_valid1);
      end
    end
    n_checks++;
    if (w_obs !== model_vec()) begin
      n_fail++; $display("FAIL reset_model: got %h want %h", w_obs, model_vec());
    end
  endtask

  task automatic test_alternating();
    int pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick(codes[$urandom_range(0, 15)], 1'((i / 2) % 2), 1'b1, 1'b0);
      pulses += int'(o_update);
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL alternating: pulses=%0d want 0", pulses);
    end
  endtask

  task automatic test_random();
    logic [6:0] seg = 7'h7E;
    logic       dig = 1'b0;
    int         bad = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) < 25) begin
        case ($urandom_range(0, 3))
          0:       seg = 7'h00;
          1:       seg = 7'($urandom);
          default: seg = codes[$urandom_range(0, 15)];
        endcase
        dig = 1'($urandom);
      end
      tick(seg, dig, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 5);
      n_checks++;
      if (w_obs !== model_vec()) begin
        n_fail++;
        if (bad++ < 10) $display("FAIL random[%0d]: got %h want %h", i, w_obs, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_digit0_hold();
    test_digit1();
    test_short_run();
    test_illegal();
    test_enable_gap();
    test_reset_mid();
    test_alternating();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
